div_unit: RTL

Iterative 32-bit divider for the Atom core's M extension, sitting beside the ALU in the execute stage. It takes the same operand pair and `ALU_FUNC_*` select code as the ALU, and produces DIV/DIVU/REM/REMU results over multiple cycles. Those results are muxed into the writeback path downstream of the ALU. A valid/ready handshake lets the pipeline stall while a division is in flight.

---
 rtl/div_unit_pkg.sv | 20 ++
 rtl/div_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants for the M-extension divider: ALU function codes and the
// iterative latency used by the hazard/stall logic and the testbench.
package div_unit_pkg;

    localparam logic [3:0] ALU_FUNC_DIV  = 4'hC;
    localparam logic [3:0] ALU_FUNC_DIVU = 4'hD;
    localparam logic [3:0] ALU_FUNC_REM  = 4'hE;
    localparam logic [3:0] ALU_FUNC_REMU = 4'hF;

    localparam int DIV_LATENCY = 32;

    function automatic logic is_signed_op(input logic [3:0] sel);
        return (sel == ALU_FUNC_DIV) || (sel == ALU_FUNC_REM);
    endfunction

    function automatic logic is_rem_op(input logic [3:0] sel);
        return (sel == ALU_FUNC_REM) || (sel == ALU_FUNC_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU/REM/REMU) with valid/ready
// handshakes on both sides and a fast path for divide-by-zero and overflow.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [3:0]  sel_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_sel;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [4:0]  r_count;
    logic [31:0] r_result;

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic        w_overflow;
    logic [32:0] w_rem_shift;
    logic [33:0] w_diff;
    logic        w_borrow;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_final;

    assign w_signed   = is_signed_op(sel_i);
    assign w_a_neg    = w_signed & a_i[31];
    assign w_b_neg    = w_signed & b_i[31];
    assign w_a_mag    = w_a_neg ? (~a_i + 32'd1) : a_i;
    assign w_b_mag    = w_b_neg ? (~b_i + 32'd1) : b_i;
    assign w_div_zero = (b_i == 32'd0);
    assign w_overflow = w_signed && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

    // One restoring step; bit 33 of the difference is the borrow, i.e. the trial sign.
    assign w_rem_shift = {r_rem, r_quo[31]};
    assign w_diff      = {1'b0, w_rem_shift} - {2'b00, r_divisor};
    assign w_borrow    = w_diff[33];
    assign w_rem_next  = w_borrow ? w_rem_shift[31:0] : w_diff[31:0];
    assign w_quo_next  = {r_quo[30:0], ~w_borrow};

    assign w_quo_fix = r_neg_q ? (~w_quo_next + 32'd1) : w_quo_next;
    assign w_rem_fix = r_neg_r ? (~w_rem_next + 32'd1) : w_rem_next;
    assign w_final   = is_rem_op(r_sel) ? w_rem_fix : w_quo_fix;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_sel     <= ALU_FUNC_DIVU;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_count   <= 5'd0;
            r_result  <= 32'd0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_sel     <= sel_i;
                        r_rem     <= 32'd0;
                        r_quo     <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_count   <= 5'd0;
                        if (w_div_zero) begin
                            r_result <= is_rem_op(sel_i) ? a_i : 32'hFFFF_FFFF;
                            r_state  <= S_DONE;
                        end else if (w_overflow) begin
                            r_result <= is_rem_op(sel_i) ? 32'd0 : 32'h8000_0000;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'(DIV_LATENCY - 1)) begin
                        r_result <= w_final;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_o  = (r_state == S_IDLE);
    assign valid_o  = (r_state == S_DONE);
    assign busy_o   = (r_state != S_IDLE);
    assign result_o = r_result;

endmodule
